// File: rtl/rv32i_pkg.sv
// rv32i_pkg -- definitions shared by the branch-resolution block and its
// comparator.
//   state_t        : branch controller FSM states
//   BEQ..BGEU      : conditional-branch funct3 encodings
//   F3_ILL_*       : funct3 codes that have no branch meaning
package rv32i_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CMP      = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  localparam logic [2:0] BEQ      = 3'b000;
  localparam logic [2:0] BNE      = 3'b001;
  localparam logic [2:0] F3_ILL_A = 3'b010;
  localparam logic [2:0] F3_ILL_B = 3'b011;
  localparam logic [2:0] BLT      = 3'b100;
  localparam logic [2:0] BGE      = 3'b101;
  localparam logic [2:0] BLTU     = 3'b110;
  localparam logic [2:0] BGEU     = 3'b111;

endpackage

// File: rtl/brc.sv
// brc -- purely combinational branch comparator.
//   i_a, i_b : 32-bit operands (rs1, rs2)
//   i_un     : 1 = unsigned compare, 0 = signed compare
//   o_eq     : i_a == i_b
//   o_lt     : i_a <  i_b under the selected signedness
module brc (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_un,
  output logic        o_eq,
  output logic        o_lt
);

  always_comb begin
    o_eq = (i_a == i_b);
    if (i_un) o_lt = (i_a < i_b);
    else      o_lt = ($signed(i_a) < $signed(i_b));
  end

endmodule

// File: rtl/br_ctrl.sv
// br_ctrl -- resolves one branch/jal/jalr per operation.
//   i_clk, i_rst_n         : clock, synchronous active-low reset
//   i_valid / o_ready      : instruction handshake (accept in IDLE only)
//   i_is_branch/jal/jalr   : one-hot op class
//   i_funct3, i_pc, i_imm,
//   i_rs1_data, i_rs2_data : operands, captured at accept
//   o_done                 : one-cycle resolve pulse (accept + 1)
//   o_taken, o_link        : outcome and pc+4, valid with o_done
//   o_illegal, o_misalign  : exception pulses with o_done
//   o_redirect_valid/pc,
//   i_redirect_ready       : fetch redirect handshake for taken ops
//   i_flush                : abort whatever is in flight
//   o_taken_cnt            : count of taken conditional branches
module br_ctrl
  import rv32i_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_is_branch,
  input  logic        i_is_jal,
  input  logic        i_is_jalr,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_imm,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  output logic        o_done,
  output logic        o_taken,
  output logic [31:0] o_link,
  output logic        o_redirect_valid,
  input  logic        i_redirect_ready,
  output logic [31:0] o_redirect_pc,
  output logic        o_illegal,
  output logic        o_misalign,
  input  logic        i_flush,
  output logic [15:0] o_taken_cnt
);

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_pc;
  logic [31:0] r_imm;
  logic [31:0] r_rs1;
  logic [31:0] r_rs2;
  logic [2:0]  r_funct3;
  logic        r_is_branch;
  logic        r_is_jal;
  logic        r_is_jalr;
  logic [31:0] r_redirect_pc;
  logic [15:0] r_taken_cnt;

  logic        w_live;
  logic        w_accept;
  logic        w_in_cmp;
  logic        w_br_un;
  logic        w_eq;
  logic        w_lt;
  logic        w_cond;
  logic        w_illegal;
  logic        w_is_jump;
  logic [31:0] w_pc_imm;
  logic [31:0] w_rs1_imm;
  logic [31:0] w_target;
  logic        w_raw_taken;
  logic        w_misalign;
  logic        w_taken;

  // Reset and flush both kill any visible activity in the current cycle.
  assign w_live   = i_rst_n & ~i_flush;
  assign w_accept = i_valid & o_ready;
  assign w_in_cmp = (r_state == ST_CMP) & w_live;

  assign w_br_un = (r_funct3 == BLTU) | (r_funct3 == BGEU);

  brc u_brc (
    .i_a  (r_rs1),
    .i_b  (r_rs2),
    .i_un (w_br_un),
    .o_eq (w_eq),
    .o_lt (w_lt)
  );

  always_comb begin
    w_cond = 1'b0;
    case (r_funct3)
      BEQ:          w_cond = w_eq;
      BNE:          w_cond = ~w_eq;
      BLT,  BLTU:   w_cond = w_lt;
      BGE,  BGEU:   w_cond = ~w_lt;
      default:      w_cond = 1'b0;
    endcase
  end

  assign w_illegal = r_is_branch & ((r_funct3 == F3_ILL_A) | (r_funct3 == F3_ILL_B));
  assign w_is_jump = r_is_jal | r_is_jalr;

  // Targets wrap modulo 2^32; jalr drops bit 0 before the alignment check.
  assign w_pc_imm  = r_pc + r_imm;
  assign w_rs1_imm = r_rs1 + r_imm;
  assign w_target  = r_is_jalr ? {w_rs1_imm[31:1], 1'b0} : w_pc_imm;

  assign w_raw_taken = w_is_jump | (r_is_branch & ~w_illegal & w_cond);
  assign w_misalign  = w_raw_taken & w_target[1];
  // A misaligned target is reported as an exception, never as a taken op.
  assign w_taken     = w_raw_taken & ~w_misalign;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_next = r_state;
    if (i_flush) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:     if (w_accept) w_state_next = ST_CMP;
        ST_CMP:      w_state_next = w_taken ? ST_REDIRECT : ST_IDLE;
        ST_REDIRECT: if (i_redirect_ready) w_state_next = ST_IDLE;
        default:     w_state_next = ST_IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    o_ready          = (r_state == ST_IDLE) & w_live;
    o_done           = w_in_cmp;
    o_taken          = w_in_cmp & w_taken;
    o_illegal        = w_in_cmp & w_illegal;
    o_misalign       = w_in_cmp & w_misalign;
    o_link           = (w_in_cmp & w_is_jump) ? (r_pc + 32'd4) : 32'd0;
    o_redirect_valid = (r_state == ST_REDIRECT) & w_live;
    o_redirect_pc    = r_redirect_pc;
    o_taken_cnt      = r_taken_cnt;
  end

  // ---------------- Datapath registers ----------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pc          <= '0;
      r_imm         <= '0;
      r_rs1         <= '0;
      r_rs2         <= '0;
      r_funct3      <= '0;
      r_is_branch   <= 1'b0;
      r_is_jal      <= 1'b0;
      r_is_jalr     <= 1'b0;
      r_redirect_pc <= '0;
      r_taken_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_pc        <= i_pc;
        r_imm       <= i_imm;
        r_rs1       <= i_rs1_data;
        r_rs2       <= i_rs2_data;
        r_funct3    <= i_funct3;
        r_is_branch <= i_is_branch;
        r_is_jal    <= i_is_jal;
        r_is_jalr   <= i_is_jalr;
      end
      // Target is frozen here so it stays stable for the whole redirect.
      if (w_in_cmp & w_taken)
        r_redirect_pc <= w_target;
      if (w_in_cmp & w_taken & r_is_branch)
        r_taken_cnt <= r_taken_cnt + 16'd1;
    end
  end

endmodule
